// File: rtl/pe_pkg.sv
// Shared mode encodings and MAC FSM state type for the processing element.
package pe_pkg;
  typedef logic [1:0] pe_mode_t;

  localparam pe_mode_t MODE_MAC     = 2'd0;
  localparam pe_mode_t MODE_MUL_ADD = 2'd1;
  localparam pe_mode_t MODE_LOAD    = 2'd2;
  localparam pe_mode_t MODE_CLEAR   = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pe_state_e;
endpackage

// File: rtl/pe_param_if.sv
// Operand/result bundle of one processing element; upstream drives through
// the master modport and the PE sits on the slave modport.
interface pe_param_if #(
  parameter int DW   = 8,
  parameter int KMAX = 9
);
  import pe_pkg::*;
  localparam int CW = $clog2(KMAX + 1);

  pe_mode_t               mode_i;
  logic                   valid_i;
  logic signed [DW-1:0]   pe_in;
  logic signed [DW-1:0]   pe_filter;
  logic signed [DW-1:0]   psum_in;
  logic        [CW-1:0]   acc_len;

  logic signed [DW-1:0]   pe_in_o;
  logic                   valid_o;
  pe_mode_t               mode_o;
  logic signed [DW-1:0]   pe_out;
  logic                   out_valid;
  logic                   sat_o;
  logic                   busy;

  modport master (
    output mode_i, valid_i, pe_in, pe_filter, psum_in, acc_len,
    input  pe_in_o, valid_o, mode_o, pe_out, out_valid, sat_o, busy
  );

  modport slave (
    input  mode_i, valid_i, pe_in, pe_filter, psum_in, acc_len,
    output pe_in_o, valid_o, mode_o, pe_out, out_valid, sat_o, busy
  );
endinterface

// File: rtl/pe_sat.sv
// Arithmetic right shift by SHIFT followed by saturation to a signed DW-bit range.
module pe_sat #(
  parameter int IN_W  = 17,
  parameter int DW    = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [DW-1:0]   dout,
  output logic                   sat
);
  localparam logic signed [IN_W-1:0] MAX_W = {{(IN_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_W = {{(IN_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   MAX_O = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   MIN_O = {1'b1, {(DW-1){1'b0}}};

  // Result packs {clipped flag, saturated value}.
  function automatic logic [DW:0] shift_sat(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] sh;
    sh = x >>> SHIFT;
    if (sh > MAX_W)      shift_sat = {1'b1, MAX_O};
    else if (sh < MIN_W) shift_sat = {1'b1, MIN_O};
    else                 shift_sat = {1'b0, sh[DW-1:0]};
  endfunction

  always_comb begin
    {sat, dout} = shift_sat(din);
  end
endmodule

// File: rtl/pe_param.sv
// Systolic processing element: windowed MAC, single-cycle MUL_ADD, weight
// load and clear, with one-cycle forwarding of activation, valid and mode.
module pe_param
  import pe_pkg::*;
#(
  parameter int DW    = 8,
  parameter int KMAX  = 9,
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  pe_param_if.slave  bus
);
  localparam int CW = $clog2(KMAX + 1);
  localparam int PW = 2 * DW;
  localparam int MW = 2 * DW + 1;
  localparam int AW = 2 * DW + $clog2(KMAX);
  localparam logic [CW-1:0] KMAX_C = CW'(KMAX);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  pe_state_e               state_q, state_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic        [CW-1:0]    len_q, len_d;
  logic signed [DW-1:0]    weight_q, weight_d;
  logic signed [DW-1:0]    pe_in_o_q, pe_in_o_d;
  logic                    valid_o_q, valid_o_d;
  pe_mode_t                mode_o_q, mode_o_d;
  logic signed [DW-1:0]    pe_out_q, pe_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sat_q, sat_d;

  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc_sum;
  logic signed [MW-1:0]    ma_sum;
  logic        [CW-1:0]    len_eff, len_cur, cnt_new;
  logic                    mac_go, mac_done;
  logic signed [DW-1:0]    mac_res, ma_res;
  logic                    mac_sat, ma_sat;

  // Stage 0: product, running sum and window-completion decode
  always_comb begin
    prod     = bus.pe_in * weight_q;
    acc_sum  = (state_q == ST_ACC) ? acc_q + AW'(prod) : AW'(prod);
    ma_sum   = MW'(prod) + MW'(bus.psum_in);
    if (bus.acc_len == '0)        len_eff = ONE_C;
    else if (bus.acc_len > KMAX_C) len_eff = KMAX_C;
    else                          len_eff = bus.acc_len;
    len_cur  = (state_q == ST_ACC) ? len_q : len_eff;
    cnt_new  = (state_q == ST_ACC) ? cnt_q + ONE_C : ONE_C;
    mac_go   = bus.valid_i && (bus.mode_i == MODE_MAC);
    mac_done = mac_go && (cnt_new == len_cur);
  end

  pe_sat #(.IN_W(AW), .DW(DW), .SHIFT(SHIFT)) u_sat_mac (
    .din(acc_sum), .dout(mac_res), .sat(mac_sat)
  );

  pe_sat #(.IN_W(MW), .DW(DW), .SHIFT(SHIFT)) u_sat_ma (
    .din(ma_sum), .dout(ma_res), .sat(ma_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Any qualified non-MAC operation also aborts an open window.
  always_comb begin
    state_d = state_q;
    if (bus.valid_i) state_d = (mac_go && !mac_done) ? ST_ACC : ST_IDLE;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    weight_d    = weight_q;
    pe_out_d    = pe_out_q;
    out_valid_d = 1'b0;
    sat_d       = 1'b0;
    pe_in_o_d   = bus.pe_in;
    valid_o_d   = bus.valid_i;
    mode_o_d    = bus.mode_i;
    if (bus.valid_i) begin
      case (bus.mode_i)
        MODE_MAC: begin
          if (state_q == ST_IDLE) len_d = len_eff;
          if (mac_done) begin
            acc_d       = '0;
            cnt_d       = '0;
            pe_out_d    = mac_res;
            sat_d       = mac_sat;
            out_valid_d = 1'b1;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_new;
          end
        end
        MODE_MUL_ADD: begin
          acc_d       = '0;
          cnt_d       = '0;
          pe_out_d    = ma_res;
          sat_d       = ma_sat;
          out_valid_d = 1'b1;
        end
        MODE_LOAD: begin
          weight_d = bus.pe_filter;
          acc_d    = '0;
          cnt_d    = '0;
        end
        default: begin
          acc_d = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Stage 1: registered results and forwarded operands
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      weight_q    <= '0;
      pe_out_q    <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      pe_in_o_q   <= '0;
      valid_o_q   <= 1'b0;
      mode_o_q    <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      weight_q    <= weight_d;
      pe_out_q    <= pe_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      pe_in_o_q   <= pe_in_o_d;
      valid_o_q   <= valid_o_d;
      mode_o_q    <= mode_o_d;
    end
  end

  always_comb begin
    bus.busy      = (state_q == ST_ACC);
    bus.pe_out    = pe_out_q;
    bus.out_valid = out_valid_q;
    bus.sat_o     = sat_q;
    bus.pe_in_o   = pe_in_o_q;
    bus.valid_o   = valid_o_q;
    bus.mode_o    = mode_o_q;
  end
endmodule

// File: tb/tb_pe_param.sv
// Directed bench for pe_param: MAC windows, MUL_ADD, saturation, stalls,
// aborts, window-length edges, clear, reset and forwarding.
module tb_pe_param;
  import pe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  pe_param_if #(.DW(8), .KMAX(9)) bus ();

  pe_param #(.DW(8), .KMAX(9), .SHIFT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  // Apply one cycle of inputs, then sample just after the capturing edge.
  task automatic drive(input pe_mode_t m, input logic v, input int pin,
                       input int filt, input int psum, input int len);
    bus.mode_i    = m;
    bus.valid_i   = v;
    bus.pe_in     = pin[7:0];
    bus.pe_filter = filt[7:0];
    bus.psum_in   = psum[7:0];
    bus.acc_len   = len[3:0];
    @(posedge clk);
    #1;
    if (rst) begin
      chk("fwd_pe_in", bus.pe_in_o, pin);
      chk("fwd_valid", bus.valid_o, v);
      chk("fwd_mode",  bus.mode_o,  m);
    end else begin
      chk("rst_pe_in_o", bus.pe_in_o, 0);
      chk("rst_valid_o", bus.valid_o, 0);
      chk("rst_mode_o",  bus.mode_o,  0);
    end
  endtask

  task automatic idle();
    drive(MODE_MAC, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic out(input string tag, input logic ov, input int po, input logic st);
    chk({tag, "_out_valid"}, bus.out_valid, ov);
    chk({tag, "_pe_out"},    bus.pe_out,    po);
    chk({tag, "_sat_o"},     bus.sat_o,     st);
  endtask

  initial begin
    bus.mode_i = MODE_MAC; bus.valid_i = 1'b0; bus.pe_in = '0;
    bus.pe_filter = '0; bus.psum_in = '0; bus.acc_len = '0;

    // reset with live inputs
    drive(MODE_MAC, 1'b1, 5, 0, 0, 3);
    idle();
    out("reset", 1'b0, 0, 1'b0);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b1;

    // windowed MAC: weight 2, 1..9 -> 90
    drive(MODE_LOAD, 1'b1, 0, 2, 0, 0);
    out("load", 1'b0, 0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      drive(MODE_MAC, 1'b1, i, 0, 0, 9);
      if (i < 9) begin
        chk("mac9_pending", bus.out_valid, 0);
        chk("mac9_busy", bus.busy, 1);
      end
    end
    out("mac9", 1'b1, 90, 1'b0);
    chk("mac9_busy_after", bus.busy, 0);
    idle();
    out("mac9_hold", 1'b0, 90, 1'b0);

    // negative saturation: weight -3, 1..9 -> -135 clipped
    drive(MODE_LOAD, 1'b1, 0, -3, 0, 0);
    for (int i = 1; i <= 9; i++) drive(MODE_MAC, 1'b1, i, 0, 0, 9);
    out("mac_negsat", 1'b1, -128, 1'b1);

    // positive saturation on MUL_ADD: 100*2 -> 127
    drive(MODE_LOAD, 1'b1, 0, 100, 0, 0);
    drive(MODE_MUL_ADD, 1'b1, 2, 0, 0, 0);
    out("muladd_possat", 1'b1, 127, 1'b1);

    // MUL_ADD latency and throughput: 5*-4 + (7..10)
    drive(MODE_LOAD, 1'b1, 0, 5, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(MODE_MUL_ADD, 1'b1, -4, 0, 7 + k, 0);
      out("muladd_b2b", 1'b1, -13 + k, 1'b0);
    end
    idle();
    out("muladd_end", 1'b0, -10, 1'b0);

    // stalled window of 3 with 2-cycle gaps; acc_len changes mid-window are ignored
    drive(MODE_LOAD, 1'b1, 0, 1, 0, 0);
    drive(MODE_MAC, 1'b1, 1, 0, 0, 3);
    chk("stall_busy0", bus.busy, 1);
    idle(); idle();
    chk("stall_gap_busy", bus.busy, 1);
    chk("stall_gap_ov", bus.out_valid, 0);
    drive(MODE_MAC, 1'b1, 1, 0, 0, 7);
    chk("stall_s2_ov", bus.out_valid, 0);
    idle(); idle();
    drive(MODE_MAC, 1'b1, 1, 0, 0, 7);
    out("stall", 1'b1, 3, 1'b0);
    chk("stall_busy_end", bus.busy, 0);

    // abort by MUL_ADD after the 2nd sample
    drive(MODE_MAC, 1'b1, 10, 0, 0, 5);
    drive(MODE_MAC, 1'b1, 20, 0, 0, 5);
    chk("abort_pre_ov", bus.out_valid, 0);
    drive(MODE_MUL_ADD, 1'b1, 3, 0, 4, 0);
    out("abort", 1'b1, 7, 1'b0);
    chk("abort_busy", bus.busy, 0);
    for (int k = 0; k < 3; k++) begin
      idle();
      out("abort_quiet", 1'b0, 7, 1'b0);
    end

    // acc_len 0 -> single-sample windows, back to back
    drive(MODE_MAC, 1'b1, 6, 0, 0, 0);
    out("len0_a", 1'b1, 6, 1'b0);
    chk("len0_busy", bus.busy, 0);
    drive(MODE_MAC, 1'b1, -7, 0, 0, 0);
    out("len0_b", 1'b1, -7, 1'b0);

    // acc_len 15 clamps to 9
    for (int i = 1; i <= 9; i++) begin
      drive(MODE_MAC, 1'b1, 1, 0, 0, 15);
      if (i < 9) chk("clamp_pending", bus.out_valid, 0);
    end
    out("clamp", 1'b1, 9, 1'b0);

    // new window in the cycle right after completion
    drive(MODE_MAC, 1'b1, 2, 0, 0, 2);
    chk("b2b_first_ov", bus.out_valid, 0);
    drive(MODE_MAC, 1'b1, 3, 0, 0, 2);
    out("b2b", 1'b1, 5, 1'b0);

    // CLEAR drops the window but keeps the weight
    drive(MODE_LOAD, 1'b1, 0, 4, 0, 0);
    drive(MODE_MAC, 1'b1, 1, 0, 0, 3);
    drive(MODE_CLEAR, 1'b1, 0, 0, 0, 0);
    out("clear", 1'b0, 5, 1'b0);
    chk("clear_busy", bus.busy, 0);
    drive(MODE_MAC, 1'b1, 1, 0, 0, 2);
    drive(MODE_MAC, 1'b1, 1, 0, 0, 2);
    out("after_clear", 1'b1, 8, 1'b0);

    // reset mid-window
    drive(MODE_MAC, 1'b1, 5, 0, 0, 4);
    drive(MODE_MAC, 1'b1, 5, 0, 0, 4);
    chk("rstwin_busy", bus.busy, 1);
    rst = 1'b0;
    drive(MODE_MAC, 1'b1, 5, 0, 0, 4);
    out("rstwin", 1'b0, 0, 1'b0);
    chk("rstwin_busy_low", bus.busy, 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      out("rst_release", 1'b0, 0, 1'b0);
      chk("rst_release_busy", bus.busy, 0);
    end
    // weight was cleared by reset: 5*0 + 3
    drive(MODE_MUL_ADD, 1'b1, 5, 0, 3, 0);
    out("weight_reset", 1'b1, 3, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pe_param.md
PE_PARAM -- requirements
Module: pe_param

Interface
REQ-001 Parameter DW, 8: data width of activations, weights, partial sums and result.
REQ-002 Parameter KMAX, 9: maximum products per MAC window.
REQ-003 Parameter SHIFT, 0: right arithmetic shift applied before output saturation.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 mode_i  in  2  0 MAC, 1 MUL_ADD, 2 LOAD, 3 CLEAR.
REQ-007 valid_i  in  1  qualifies pe_in, pe_filter, psum_in and mode_i this cycle.
REQ-008 pe_in  in  DW  signed activation.
REQ-009 pe_filter  in  DW  signed weight, captured in LOAD.
REQ-010 psum_in  in  DW  signed partial sum, used in MUL_ADD.
REQ-011 acc_len  in  CW=clog2(KMAX+1)  window length, sampled at window start.
REQ-012 pe_in_o  out  DW  pe_in delayed one cycle, for systolic forwarding.
REQ-013 valid_o  out  1  valid_i delayed one cycle.
REQ-014 mode_o  out  2  mode_i delayed one cycle; registered, not combinational.
REQ-015 pe_out  out  DW  signed saturated result; holds its value between results.
REQ-016 out_valid  out  1  one-cycle pulse marking a new pe_out.
REQ-017 sat_o  out  1  set with out_valid when the result was clipped.
REQ-018 busy  out  1  high while a MAC window is open.

Function
REQ-019 Arithmetic: signed two's complement throughout.
- Product width: 2*DW.
- Accumulator width: 2*DW+clog2(KMAX); the accumulator never overflows internally.
REQ-020 Output path: result is arithmetically shifted right by SHIFT, then saturated to [-2^(DW-1), 2^(DW-1)-1].
- sat_o is 1 exactly when saturation changed the value.
REQ-021 Forwarding: pe_in_o, valid_o and mode_o update every cycle, regardless of valid_i.
REQ-022 LOAD (valid_i, mode 2): the weight register takes pe_filter; no out_valid is produced.
REQ-023 CLEAR (valid_i, mode 3): accumulator and count go to zero and the FSM goes to IDLE.
- The weight register is retained.
- No out_valid is produced.
REQ-024 MUL_ADD (valid_i, mode 1): pe_out = sat(pe_in*weight + psum_in), with out_valid the next cycle (latency 1).
- Accepted every cycle; no back-pressure.
REQ-025 MAC FSM states: IDLE, ACC.
REQ-026 IDLE + valid_i + mode 0 starts a window:
- latch L = acc_len, with 0 treated as 1 and values above KMAX clamped to KMAX;
- acc = pe_in*weight, count = 1;
- if L = 1, complete immediately per REQ-028; otherwise go to ACC.
REQ-027 ACC + valid_i + mode 0: acc += pe_in*weight, count++.
REQ-028 Window completion: on the cycle the Lth product is accepted:
- next cycle, pe_out = sat(acc including that product) and out_valid = 1;
- acc and count are cleared and the FSM returns to IDLE.
REQ-029 Back-to-back windows: a mode-0 sample in the cycle after completion starts a new window with no bubble.
REQ-030 ACC with valid_i low: stall; acc, count and L hold.
REQ-031 ACC + valid_i with mode other than 0: the window is aborted without output.
- The accumulator is discarded and the FSM goes to IDLE.
- The new operation is executed in that same cycle.
REQ-032 busy = (state == ACC).
REQ-033 MUL_ADD and MAC completion are mutually exclusive by construction (REQ-031), so at most one out_valid source fires per cycle.

Reset
REQ-034 While rst = 0 at a clock edge, the following are all cleared to zero:
- pe_out, pe_in_o, mode_o, valid_o, out_valid, sat_o;
- weight, accumulator, count, L.
REQ-035 While rst = 0 at a clock edge, the FSM goes to IDLE and busy = 0.
REQ-036 Reset asserted mid-window discards the window; no out_valid follows reset release.

Structure
REQ-037 Shared package pe_pkg holds the mode constants MODE_MAC, MODE_MUL_ADD, MODE_LOAD, MODE_CLEAR and the FSM state typedef.
REQ-038 Shift-and-saturate is a sub-module, pe_sat, parametrised by input width, DW and SHIFT, and used by both result paths.

Verification
REQ-039 Windowed MAC:
- LOAD 2, then MAC with acc_len = 9 and pe_in = 1..9 on consecutive cycles;
- expect pe_out = 90 with out_valid one cycle after the 9th sample, sat_o = 0, busy low afterwards.
REQ-040 Saturation:
- LOAD -3, then MAC with acc_len = 9 and pe_in = 1..9 -> pe_out = -128, sat_o = 1.
- LOAD 100, then MUL_ADD with pe_in = 2 and psum_in = 0 -> pe_out = 127, sat_o = 1.
REQ-041 MUL_ADD latency: weight 5, pe_in = -4, psum_in = 7 -> pe_out = -13 with out_valid exactly one cycle later.
- Repeat on 4 consecutive cycles and expect 4 consecutive pulses.
REQ-042 Stall, abort and length edge cases:
- MAC with acc_len = 3 and valid_i gaps of 2 cycles between samples 1,1,1, weight 1 -> single result 3.
- A MUL_ADD issued after the 2nd MAC sample aborts the window; only the MUL_ADD result appears.
- acc_len = 0 gives 1-sample windows.
REQ-043 Reset and forwarding:
- rst low during ACC -> all outputs 0 and no out_valid after release.
- pe_in_o, valid_o and mode_o equal the inputs delayed exactly one cycle throughout.
